// File: rtl/med_window_feeder.sv
// rtl/med_window_feeder.sv - 3x3 window builder that serialises each interior window to the median stage
// Optional WIN_CNT output (windows issued this frame) is enabled by MED_FEEDER_WINCNT_EN.
module med_window_feeder #(
  parameter int width = 8,
  parameter int IMG_W = 16,
  parameter int IMG_H = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [width-1:0] PIX_IN,
  input  logic             PIX_VALID,
  input  logic             PIX_SOF,
  output logic             PIX_READY,
  output logic [width-1:0] DO,
  output logic             DSO,
  input  logic             MED_DONE,
  output logic             FRAME_DONE
`ifdef MED_FEEDER_WINCNT_EN
  ,
  output logic [15:0]      WIN_CNT
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t           state;
  logic [3:0]       cnt;
  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic [CW-1:0]    eff_col;
  logic [RW-1:0]    eff_row;
  logic [width-1:0] lb1 [IMG_W];
  logic [width-1:0] lb2 [IMG_W];
  logic [width-1:0] win [9];
  logic             last_win;
  logic             accept;
  logic             win_hit;

  // A SOF accept is always placed at (0,0) regardless of where the counters are.
  assign accept  = PIX_VALID & PIX_READY;
  assign eff_col = PIX_SOF ? '0 : col;
  assign eff_row = PIX_SOF ? '0 : row;
  assign win_hit = (eff_row >= ROW_TWO) && (eff_col >= COL_TWO);

  assign FRAME_DONE = (state == WAIT) && MED_DONE && last_win;

  always_ff @(posedge CLK) begin
    if (accept) begin
      lb2[eff_col] <= lb1[eff_col];
      lb1[eff_col] <= PIX_IN;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      PIX_READY <= 1'b1;
      DSO       <= 1'b0;
      DO        <= '0;
      col       <= '0;
      row       <= '0;
      last_win  <= 1'b0;
      for (int i = 0; i < 9; i++) win[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            win[0] <= win[1];
            win[1] <= win[2];
            win[2] <= lb2[eff_col];
            win[3] <= win[4];
            win[4] <= win[5];
            win[5] <= lb1[eff_col];
            win[6] <= win[7];
            win[7] <= win[8];
            win[8] <= PIX_IN;
            if (eff_col == COL_LAST) begin
              col <= '0;
              row <= (eff_row == ROW_LAST) ? '0 : eff_row + RW'(1);
            end else begin
              col <= eff_col + CW'(1);
              row <= eff_row;
            end
            if (win_hit) begin
              // win[1] becomes the new top-left after this shift, so it leads the burst.
              state     <= SEND;
              PIX_READY <= 1'b0;
              DSO       <= 1'b1;
              DO        <= win[1];
              cnt       <= 4'd1;
              last_win  <= (eff_row == ROW_LAST) && (eff_col == COL_LAST);
            end
          end
        end
        SEND: begin
          if (cnt == 4'd9) begin
            state <= WAIT;
            DSO   <= 1'b0;
          end else begin
            DO  <= win[cnt];
            cnt <= cnt + 4'd1;
          end
        end
        WAIT: begin
          if (MED_DONE) begin
            state     <= IDLE;
            PIX_READY <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          PIX_READY <= 1'b1;
          DSO       <= 1'b0;
        end
      endcase
    end
  end

`ifdef MED_FEEDER_WINCNT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      WIN_CNT <= '0;
    end else if (state == IDLE && accept) begin
      if (PIX_SOF) WIN_CNT <= '0;
      else if (win_hit && WIN_CNT != 16'hFFFF) WIN_CNT <= WIN_CNT + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_med_window_feeder.sv
// tb/tb_med_window_feeder.sv - self-checking bench for med_window_feeder (4x4 frames, PIX_IN = 4*row+col)
`timescale 1ns/1ps
module tb_med_window_feeder;
  localparam int W  = 8;
  localparam int IW = 4;
  localparam int IH = 4;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic [W-1:0] PIX_IN = '0;
  logic         PIX_VALID = 1'b0;
  logic         PIX_SOF = 1'b0;
  logic         MED_DONE = 1'b0;
  logic         PIX_READY;
  logic         DSO;
  logic         FRAME_DONE;
  logic [W-1:0] DO;
`ifdef MED_FEEDER_WINCNT_EN
  logic [15:0]  WIN_CNT;
`endif

  med_window_feeder #(.width(W), .IMG_W(IW), .IMG_H(IH)) dut (
    .CLK(CLK), .RST(RST), .PIX_IN(PIX_IN), .PIX_VALID(PIX_VALID), .PIX_SOF(PIX_SOF),
    .PIX_READY(PIX_READY), .DO(DO), .DSO(DSO), .MED_DONE(MED_DONE), .FRAME_DONE(FRAME_DONE)
`ifdef MED_FEEDER_WINCNT_EN
    , .WIN_CNT(WIN_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  int n_pass = 0;
  int n_total = 0;

  // behavioural model: a frame image plus "busy / burst cycles left" bookkeeping
  int img [IH][IW];
  int cur_win [9];
  int busy = 0, send_left = 0, mrow = 0, mcol = 0, m_wincnt = 0, cur_last = 0;

  // median responder and observation logs
  int med_auto = 1, med_delay = 40, wait_cnt = 0;
  int do_log[$];
  int run_log[$];
  int cur_run = 0, prev_dso = 0, last_do = 0, fd_cnt = 0, dut_acc = 0;

  int b1 [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
  int b2 [9] = '{1, 2, 3, 5, 6, 7, 9, 10, 11};

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual %0d required %0d", name, act, exp);
  endtask

  task automatic model_step();
    int r, c, was_busy;
    if (RST) begin
      busy = 0; send_left = 0; mrow = 0; mcol = 0; m_wincnt = 0; cur_last = 0;
      return;
    end
    was_busy = busy;
    if (send_left > 0) send_left--;
    else if (busy != 0 && MED_DONE) busy = 0;
    if (PIX_VALID && was_busy == 0) begin
      r = PIX_SOF ? 0 : mrow;
      c = PIX_SOF ? 0 : mcol;
      if (PIX_SOF) m_wincnt = 0;
      img[r][c] = int'(PIX_IN);
      if (r >= 2 && c >= 2) begin
        for (int i = 0; i < 9; i++) cur_win[i] = img[r - 2 + i / 3][c - 2 + i % 3];
        cur_last  = (r == IH - 1 && c == IW - 1) ? 1 : 0;
        busy      = 1;
        send_left = 9;
        if (m_wincnt < 65535) m_wincnt++;
      end
      mrow = r;
      mcol = c + 1;
      if (mcol == IW) begin
        mcol = 0;
        mrow = (r + 1) % IH;
      end
    end
  endtask

  task automatic compare();
    int exp_dso, exp_fd;
    if (RST) begin
      last_do = 0; prev_dso = 0; cur_run = 0;
      return;
    end
    exp_dso = (send_left > 0) ? 1 : 0;
    chk("dso", int'(DSO), exp_dso);
    chk("pix_ready", int'(PIX_READY), (busy != 0) ? 0 : 1);
    if (exp_dso != 0) begin
      chk("do", int'(DO), cur_win[9 - send_left]);
      last_do = cur_win[9 - send_left];
    end else begin
      chk("do_hold", int'(DO), last_do);
    end
    exp_fd = (MED_DONE && busy != 0 && send_left == 0 && cur_last != 0) ? 1 : 0;
    chk("frame_done", int'(FRAME_DONE), exp_fd);
`ifdef MED_FEEDER_WINCNT_EN
    chk("win_cnt", int'(WIN_CNT), m_wincnt);
`endif
    if (DSO) begin
      do_log.push_back(int'(DO));
      cur_run++;
    end else if (prev_dso != 0) begin
      run_log.push_back(cur_run);
      cur_run = 0;
    end
    prev_dso = int'(DSO);
    if (FRAME_DONE) fd_cnt++;
    if (PIX_VALID && PIX_READY) dut_acc++;
  endtask

  // one clock: check mid-cycle, advance the model on the edge, drive new inputs 1ns later
  task automatic tick();
    @(negedge CLK);
    compare();
    @(posedge CLK);
    model_step();
    #1;
    wait_cnt = (busy != 0 && send_left == 0) ? wait_cnt + 1 : 0;
    if (med_auto != 0) MED_DONE = (wait_cnt == med_delay);
  endtask

  task automatic send_pix(input int v, input bit sof);
    int ok = 0;
    PIX_IN = W'(v);
    PIX_SOF = sof;
    PIX_VALID = 1'b1;
    for (int k = 0; k < 2000 && ok == 0; k++) begin
      ok = (busy == 0) ? 1 : 0;
      tick();
    end
    chk("accept_timeout", ok, 1);
    PIX_VALID = 1'b0;
    PIX_SOF = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 2000 && busy != 0; k++) tick();
    chk("idle_timeout", busy, 0);
  endtask

  task automatic check_frame(input string tag, input int mdo, input int mrun, input int mfd);
    chk({tag, "_do_count"}, do_log.size() - mdo, 36);
    if (do_log.size() - mdo >= 18) begin
      for (int k = 0; k < 9; k++) chk({tag, "_burst1"}, do_log[mdo + k], b1[k]);
      for (int k = 0; k < 9; k++) chk({tag, "_burst2"}, do_log[mdo + 9 + k], b2[k]);
    end
    chk({tag, "_bursts"}, run_log.size() - mrun, 4);
    for (int k = mrun; k < run_log.size(); k++) chk({tag, "_burst_len"}, run_log[k], 9);
    chk({tag, "_frame_done_pulses"}, fd_cnt - mfd, 1);
  endtask

  initial begin
    int mdo, mrun, mfd, macc;

    RST = 1'b1;
    tick();
    tick();
    chk("reset_ready", int'(PIX_READY), 1);
    chk("reset_dso", int'(DSO), 0);
    chk("reset_do", int'(DO), 0);
    chk("reset_frame_done", int'(FRAME_DONE), 0);
    RST = 1'b0;
    tick();

    // window content and per-frame counts
    mdo = do_log.size(); mrun = run_log.size(); mfd = fd_cnt;
    med_auto = 1; med_delay = 40;
    for (int i = 0; i < 16; i++) send_pix(i, i == 0);
    wait_idle();
    repeat (3) tick();
    check_frame("frame1", mdo, mrun, mfd);

    // rows 0-1 with random valid gaps
    med_delay = 3;
    mdo = do_log.size(); macc = dut_acc;
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      send_pix(i, i == 0);
    end
    tick();
    chk("rows01_accepts", dut_acc - macc, 8);
    chk("rows01_no_dso", do_log.size() - mdo, 0);
    for (int i = 8; i < 16; i++) send_pix(i, 1'b0);
    wait_idle();

    // stall until MED_DONE; a pulse during SEND is ignored
    med_auto = 0;
    for (int i = 0; i < 11; i++) send_pix(i, i == 0);
    MED_DONE = 1'b1;
    tick();
    MED_DONE = 1'b0;
    repeat (109) tick();
    chk("stall_ready", int'(PIX_READY), 0);
    chk("stall_dso", int'(DSO), 0);
    MED_DONE = 1'b1;
    tick();
    MED_DONE = 1'b0;
    chk("release_ready", int'(PIX_READY), 1);
    med_auto = 1;
    for (int i = 11; i < 16; i++) send_pix(i, 1'b0);
    wait_idle();

    // resync with SOF at (2,1) of a stale frame
    for (int i = 0; i < 9; i++) send_pix(200 + i, i == 0);
    mdo = do_log.size(); mfd = fd_cnt;
    send_pix(0, 1'b1);
    for (int i = 1; i < 10; i++) send_pix(i, 1'b0);
    tick();
    chk("resync_no_burst", do_log.size() - mdo, 0);
    send_pix(10, 1'b0);
    wait_idle();
    chk("resync_do_count", do_log.size() - mdo, 9);
    if (do_log.size() - mdo >= 9)
      for (int k = 0; k < 9; k++) chk("resync_burst", do_log[mdo + k], b1[k]);
    for (int i = 11; i < 16; i++) send_pix(i, 1'b0);
    wait_idle();
    repeat (2) tick();
    chk("resync_frame_done", fd_cnt - mfd, 1);

    // asynchronous reset on the 5th DSO cycle
    med_delay = 40;
    for (int i = 0; i < 11; i++) send_pix(i, i == 0);
    repeat (4) tick();
    chk("dso_before_reset", int'(DSO), 1);
    RST = 1'b1;
    #1;
    chk("async_reset_dso", int'(DSO), 0);
    chk("async_reset_ready", int'(PIX_READY), 1);
    chk("async_reset_do", int'(DO), 0);
`ifdef MED_FEEDER_WINCNT_EN
    chk("async_reset_win_cnt", int'(WIN_CNT), 0);
`endif
    tick();
    RST = 1'b0;
    tick();
    mdo = do_log.size(); mrun = run_log.size(); mfd = fd_cnt;
    for (int i = 0; i < 16; i++) send_pix(i, i == 0);
    wait_idle();
    repeat (3) tick();
    check_frame("after_reset", mdo, mrun, mfd);
`ifdef MED_FEEDER_WINCNT_EN
    chk("win_cnt_end_of_frame", int'(WIN_CNT), 4);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
